sparse_result_collector: RTL
============================

// Module: sparse_result_collector
// PURPOSE
// - Downstream of the row-wise sparse x dense multiply stage. Captures its 64-bit result pairs (valid beats) and zero-row pulses.
// - Tags each pair with output row / column-pair index; buffers pairs in a small FIFO; presents them on a ready/valid stream to the result writer.
// - Upstream has no backpressure: FIFO absorbs bursts; overflow is dropped and flagged.
// PARAMETERS
// - DATA_W         64   width of each result value
// - PAIRS_PER_ROW  280  result pairs per output row (560 columns / 2)
// - NUM_ROWS       560  output rows per matrix product; done after the last one
// - ROW_W          10   width of row index
// - PAIR_W         9    width of column-pair index
// - FIFO_DEPTH     16   entries, power of two
// PORTS
// - clk        in   1         clock; all logic on posedge
// - rst        in   1         synchronous, active-low reset
// - in_valid   in   1         in_data1/in_data2 hold one result pair this cycle
// - in_zeros   in   1         1-cycle pulse: current output row is entirely zero
// - in_data1   in   DATA_W    result at column 2*pair
// - in_data2   in   DATA_W    result at column 2*pair+1
// - out_valid  out  1         out_* fields valid
// - out_ready  in   1         consumer accepts when out_valid & out_ready
// - out_row    out  ROW_W     row index of presented pair
// - out_pair   out  PAIR_W    column-pair index (column = 2*out_pair)
// - out_data1  out  DATA_W    even-column value
// - out_data2  out  DATA_W    odd-column value
// - out_last   out  1         presented pair is the last of its row
// - done       out  1         all NUM_ROWS rows accounted for and FIFO drained; sticky
// - overflow   out  1         sticky: a beat arrived with FIFO full and was dropped
// - proto_err  out  1         sticky: in_valid&in_zeros together, or in_zeros with pair_cnt!=0
// BEHAVIOUR
// - Reset (rst==0 at posedge): all outputs 0; row_cnt=0, pair_cnt=0, FIFO empty, state=COLLECT. Reset mid-stream discards FIFO contents.
// - States: COLLECT -> (row_cnt reaches NUM_ROWS) -> DRAIN -> (FIFO empty) -> DONE; DONE holds until reset. ZFILL only with macro.
// - COLLECT, in_valid: push {row_cnt,pair_cnt,last,data1,data2}; last = (pair_cnt==PAIRS_PER_ROW-1).
//   pair_cnt wraps to 0 on last, and row_cnt increments. Counters advance even when the beat is dropped.
// - COLLECT, in_zeros only: no push; row_cnt++, pair_cnt=0. If pair_cnt!=0 at pulse, set proto_err (partial row abandoned).
// - in_valid & in_zeros same cycle: in_valid wins, zeros ignored, proto_err set.
// - Inputs in DRAIN/DONE are ignored; each one sets proto_err.
// - FIFO: push-to-out_valid latency 1 cycle (beat captured at edge N -> out_valid from edge N+1 when empty).
//   Push and pop in same cycle when full: pop frees space, push accepted (no overflow).
// - Handshake: out_* stable while out_valid & !out_ready; pop on out_valid & out_ready; no combinational ready->valid path.
// - row_cnt saturates at NUM_ROWS; row/pair tags are exact counter values, no arithmetic on data (pass-through, no truncation).
// - done asserts the cycle after the last FIFO entry is popped in DRAIN.
// CONFIGURATION
// - Macro ZERO_ROW_EXPAND_EN.
// - Defined: in_zeros (COLLECT, pair_cnt==0) enters ZFILL; pushes PAIRS_PER_ROW all-zero pairs for that row (one per cycle when FIFO not full, stall otherwise; out_last on final one), then row_cnt++ and return to COLLECT.
//   in_valid arriving in ZFILL is pushed if FIFO space allows (priority over zero fill), else dropped with overflow; counters of the real beat use row_cnt+1.
// - Undefined: zero rows produce no output beats; consumer infers them from gaps in out_row. ZFILL state absent.
// TESTING
// - Reset, 280 in_valid beats data1=k,data2=k+1000, out_ready=1 -> 280 outputs row 0 pair 0..279, out_last only on pair 279, no flags.
// - in_zeros at row 0 then 280 beats -> outputs carry out_row=1; without macro no row-0 beats; with macro 280 zero pairs row 0 first.
// - out_ready=0, 17 beats (DEPTH=16) -> overflow=1 on beat 17; release ready -> exactly 16 pairs, pairs 0..15 in order.
// - in_valid&in_zeros same cycle at pair 5 -> proto_err=1, beat pushed as pair 5, row_cnt unchanged.
// - NUM_ROWS=2 build, 2 full rows, ready toggled every cycle -> done=1 one cycle after final pop, later inputs set proto_err.
// - rst low for one cycle with 8 entries buffered -> next cycle out_valid=0, counters 0, flags cleared.

Source files
------------

// File: rtl/sparse_result_collector_if.sv
// Result-pair stream bundle: unbacked upstream beats in, tagged ready/valid pairs out.
// The collector takes the slave view; the producer/consumer side takes the master view.
interface sparse_result_collector_if #(
    parameter int unsigned DataW = 64,
    parameter int unsigned RowW  = 10,
    parameter int unsigned PairW = 9
);
    logic             in_valid;
    logic             in_zeros;
    logic [DataW-1:0] in_data1;
    logic [DataW-1:0] in_data2;
    logic             out_valid;
    logic             out_ready;
    logic [RowW-1:0]  out_row;
    logic [PairW-1:0] out_pair;
    logic [DataW-1:0] out_data1;
    logic [DataW-1:0] out_data2;
    logic             out_last;

    modport slave (
        input  in_valid, in_zeros, in_data1, in_data2, out_ready,
        output out_valid, out_row, out_pair, out_data1, out_data2, out_last
    );

    modport master (
        output in_valid, in_zeros, in_data1, in_data2, out_ready,
        input  out_valid, out_row, out_pair, out_data1, out_data2, out_last
    );
endinterface

// File: rtl/sparse_result_collector.sv
// Tags sparse x dense result pairs with row/pair indices and buffers them into a ready/valid
// stream. Optional zero-row expansion (ZFILL state) is enabled by defining ZERO_ROW_EXPAND_EN.
module sparse_result_collector #(
    parameter int unsigned DataW       = 64,
    parameter int unsigned PairsPerRow = 280,
    parameter int unsigned NumRows     = 560,
    parameter int unsigned RowW        = 10,
    parameter int unsigned PairW       = 9,
    parameter int unsigned FifoDepth   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    sparse_result_collector_if.slave bus,
    output logic                     done_o,
    output logic                     overflow_o,
    output logic                     proto_err_o
);
    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [RowW-1:0]  LastRow  = RowW'(NumRows - 1);
    localparam logic [PairW-1:0] LastPair = PairW'(PairsPerRow - 1);
    localparam logic [CntW-1:0]  FullCnt  = CntW'(FifoDepth);

    typedef struct packed {
        logic [RowW-1:0]  row;
        logic [PairW-1:0] pair;
        logic             last;
        logic [DataW-1:0] d1;
        logic [DataW-1:0] d2;
    } entry_t;

    typedef enum logic [1:0] {
        StCollect,
        StDrain,
`ifdef ZERO_ROW_EXPAND_EN
        StZfill,
`endif
        StDone
    } state_e;

    state_e          state_q;
    logic [RowW-1:0] row_cnt_q;
    logic [PairW-1:0] pair_cnt_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic            done_q, overflow_q, proto_err_q;
    entry_t          mem_q [FifoDepth];
    entry_t          push_ent, head;
    logic            push_req, push, pop, can_push, out_valid;
    logic            pair_last, row_last;
`ifdef ZERO_ROW_EXPAND_EN
    logic [PairW-1:0] zf_cnt_q;
    logic             zf_last;
    assign zf_last = (zf_cnt_q == LastPair);
`endif

    assign pair_last = (pair_cnt_q == LastPair);
    assign row_last  = (row_cnt_q == LastRow);
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign can_push  = (cnt_q != FullCnt) | pop;
    assign push      = push_req & can_push;
    assign cnt_d     = cnt_q + CntW'(push) - CntW'(pop);

    always_comb begin
        push_req = 1'b0;
        push_ent = '0;
        unique case (state_q)
            StCollect: begin
                push_req      = bus.in_valid;
                push_ent.row  = row_cnt_q;
                push_ent.pair = pair_cnt_q;
                push_ent.last = pair_last;
                push_ent.d1   = bus.in_data1;
                push_ent.d2   = bus.in_data2;
            end
`ifdef ZERO_ROW_EXPAND_EN
            StZfill: begin
                push_req = 1'b1;
                if (bus.in_valid) begin
                    push_ent.row  = row_cnt_q + RowW'(1);
                    push_ent.pair = pair_cnt_q;
                    push_ent.last = pair_last;
                    push_ent.d1   = bus.in_data1;
                    push_ent.d2   = bus.in_data2;
                end else begin
                    push_ent.row  = row_cnt_q;
                    push_ent.pair = zf_cnt_q;
                    push_ent.last = zf_last;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StCollect;
            row_cnt_q   <= '0;
            pair_cnt_q  <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
`ifdef ZERO_ROW_EXPAND_EN
            zf_cnt_q    <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case (state_q)
                StCollect: begin
                    if (bus.in_valid) begin
                        if (!can_push)    overflow_q  <= 1'b1;
                        if (bus.in_zeros) proto_err_q <= 1'b1;
                        if (pair_last) begin
                            pair_cnt_q <= '0;
                            row_cnt_q  <= row_cnt_q + RowW'(1);
                            if (row_last) state_q <= StDrain;
                        end else begin
                            pair_cnt_q <= pair_cnt_q + PairW'(1);
                        end
                    end else if (bus.in_zeros) begin
`ifdef ZERO_ROW_EXPAND_EN
                        if (pair_cnt_q == '0) begin
                            zf_cnt_q <= '0;
                            state_q  <= StZfill;
                        end else begin
                            proto_err_q <= 1'b1;
                            pair_cnt_q  <= '0;
                            row_cnt_q   <= row_cnt_q + RowW'(1);
                            if (row_last) state_q <= StDrain;
                        end
`else
                        if (pair_cnt_q != '0) proto_err_q <= 1'b1;
                        pair_cnt_q <= '0;
                        row_cnt_q  <= row_cnt_q + RowW'(1);
                        if (row_last) state_q <= StDrain;
`endif
                    end
                end
`ifdef ZERO_ROW_EXPAND_EN
                StZfill: begin
                    if (bus.in_zeros) proto_err_q <= 1'b1;
                    if (bus.in_valid) begin
                        if (!can_push) overflow_q <= 1'b1;
                        // A whole second row cannot be tagged while this fill is still pending.
                        if (pair_last) proto_err_q <= 1'b1;
                        pair_cnt_q <= pair_last ? '0 : pair_cnt_q + PairW'(1);
                    end else if (push) begin
                        if (zf_last) begin
                            row_cnt_q <= row_cnt_q + RowW'(1);
                            state_q   <= row_last ? StDrain : StCollect;
                        end else begin
                            zf_cnt_q <= zf_cnt_q + PairW'(1);
                        end
                    end
                end
`endif
                StDrain: begin
                    if (bus.in_valid || bus.in_zeros) proto_err_q <= 1'b1;
                    if (cnt_d == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.in_valid || bus.in_zeros) proto_err_q <= 1'b1;
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    // Gate stale storage so an empty FIFO presents all-zero fields.
    assign head          = out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.out_valid = out_valid;
    assign bus.out_row   = head.row;
    assign bus.out_pair  = head.pair;
    assign bus.out_last  = head.last;
    assign bus.out_data1 = head.d1;
    assign bus.out_data2 = head.d2;
    assign done_o        = done_q;
    assign overflow_o    = overflow_q;
    assign proto_err_o   = proto_err_q;
endmodule
